// File: rtl/arbiter32_out_fifo_if.sv
// Valid/ready/data word-stream interface used on both sides of the arbiter output FIFO.
// The master drives valid and data; the slave drives ready.
interface arbiter32_out_fifo_if #(
  parameter int WIDTH = 4
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/arbiter32_out_fifo.sv
// First-word-fall-through output FIFO behind the 32-input arbiter, with registered status and occupancy.
// Define ARB_OUT_FIFO_STATS_EN to add the stall_cnt and full_seen statistics ports.
module arbiter32_out_fifo #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  arbiter32_out_fifo_if.slave  in_if,
  arbiter32_out_fifo_if.master out_if,
`ifdef ARB_OUT_FIFO_STATS_EN
  output logic [15:0]          stall_cnt,
  output logic                 full_seen,
`endif
  output logic [AW:0]          count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Status comes only from registered pointers, so ready/valid never depend combinationally on the other side.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    push  = in_if.valid & ~full;
    pop   = ~empty & out_if.ready;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_if.data;
    end
  end

  assign in_if.ready  = ~full;
  assign out_if.valid = ~empty;
  assign out_if.data  = mem_q[rd_ptr_q[AW-1:0]];
  assign count        = wr_ptr_q - rd_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is deliberately left uncleared by reset; resetting the pointers discards its contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef ARB_OUT_FIFO_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        full_seen_q, full_seen_d;

  // Stall cycles saturate rather than wrap so a long backpressure episode stays visible.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (~empty && ~out_if.ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    full_seen_d = full_seen_q | full;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      full_seen_q <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      full_seen_q <= full_seen_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign full_seen = full_seen_q | full;
`endif

endmodule

// File: tb/tb_arbiter32_out_fifo.sv
// Directed self-checking bench for arbiter32_out_fifo; stats checks follow ARB_OUT_FIFO_STATS_EN.
module tb_arbiter32_out_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;
`ifdef ARB_OUT_FIFO_STATS_EN
  logic [15:0] stall_cnt;
  logic        full_seen;
`endif

  int errors = 0;
  int checks = 0;

  arbiter32_out_fifo_if #(.WIDTH(4)) in_if ();
  arbiter32_out_fifo_if #(.WIDTH(4)) out_if ();

  arbiter32_out_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (in_if),
    .out_if    (out_if),
`ifdef ARB_OUT_FIFO_STATS_EN
    .stall_cnt (stall_cnt),
    .full_seen (full_seen),
`endif
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it, so inputs change and outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_if.valid = 1'b0;
    in_if.data = 4'h0;
    out_if.ready = 1'b0;
    step();
    step();
    rst = 1'b1;
    checks++;
    if (out_if.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_valid_out: got %b expected 0", out_if.valid);
    end
    checks++;
    if (in_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready_out: got %b expected 1", in_if.ready);
    end
    checks++;
    if (count !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count);
    end
`ifdef ARB_OUT_FIFO_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0 || full_seen !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stats: got stall=%0d full_seen=%b expected 0/0", stall_cnt, full_seen);
    end
`endif
  endtask

  task automatic test_fill();
    out_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_if.valid = 1'b1;
      in_if.data = 4'(i);
      step();
      checks++;
      if (count !== 3'(i)) begin
        errors++; $display("[TB] FAIL fill_count_%0d: got %0d expected %0d", i, count, i);
      end
      checks++;
      if (in_if.ready !== (i < 4)) begin
        errors++; $display("[TB] FAIL fill_ready_%0d: got %b expected %b", i, in_if.ready, (i < 4));
      end
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 4'd1) begin
        errors++; $display("[TB] FAIL fill_head_%0d: got valid=%b data=%0d expected 1/1", i, out_if.valid, out_if.data);
      end
`ifdef ARB_OUT_FIFO_STATS_EN
      checks++;
      if (stall_cnt !== 16'(i - 1)) begin
        errors++; $display("[TB] FAIL fill_stall_%0d: got %0d expected %0d", i, stall_cnt, i - 1);
      end
`endif
    end
    in_if.data = 4'd5;
    step();
    in_if.valid = 1'b0;
    checks++;
    if (count !== 3'd4 || in_if.ready !== 1'b0 || out_if.data !== 4'd1) begin
      errors++; $display("[TB] FAIL fill_blocked: got count=%0d ready=%b head=%0d expected 4/0/1", count, in_if.ready, out_if.data);
    end
`ifdef ARB_OUT_FIFO_STATS_EN
    checks++;
    if (stall_cnt !== 16'd4 || full_seen !== 1'b1) begin
      errors++; $display("[TB] FAIL fill_stats: got stall=%0d full_seen=%b expected 4/1", stall_cnt, full_seen);
    end
`endif
  endtask

  task automatic test_drain();
    in_if.valid = 1'b0;
    in_if.data = 4'hF;
    out_if.ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 4'(k)) begin
        errors++; $display("[TB] FAIL drain_word_%0d: got valid=%b data=%0d expected 1/%0d", k, out_if.valid, out_if.data, k);
      end
      step();
    end
    checks++;
    if (out_if.valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("[TB] FAIL drain_empty: got valid=%b count=%0d expected 0/0", out_if.valid, count);
    end
`ifdef ARB_OUT_FIFO_STATS_EN
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++; $display("[TB] FAIL drain_stall_hold: got %0d expected 4", stall_cnt);
    end
`endif
  endtask

  task automatic test_stream();
    out_if.ready = 1'b1;
    in_if.valid = 1'b1;
    checks++;
    if (out_if.valid !== 1'b0) begin
      errors++; $display("[TB] FAIL stream_no_bypass: got valid=%b expected 0", out_if.valid);
    end
    for (int i = 0; i < 10; i++) begin
      in_if.data = 4'(i);
      step();
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 4'(i) || count !== 3'd1) begin
        errors++; $display("[TB] FAIL stream_word_%0d: got valid=%b data=%0d count=%0d expected 1/%0d/1", i, out_if.valid, out_if.data, count, i);
      end
    end
    in_if.valid = 1'b0;
    step();
    checks++;
    if (out_if.valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("[TB] FAIL stream_end: got valid=%b count=%0d expected 0/0", out_if.valid, count);
    end
  endtask

  task automatic test_full_pop();
    out_if.ready = 1'b0;
    in_if.valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_if.data = 4'(i);
      step();
    end
    out_if.ready = 1'b1;
    in_if.data = 4'd5;
    checks++;
    if (in_if.ready !== 1'b0 || count !== 3'd4) begin
      errors++; $display("[TB] FAIL fullpop_full: got ready=%b count=%0d expected 0/4", in_if.ready, count);
    end
    step();
    checks++;
    if (count !== 3'd3 || out_if.data !== 4'd2 || in_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL fullpop_cycle1: got count=%0d head=%0d ready=%b expected 3/2/1", count, out_if.data, in_if.ready);
    end
    step();
    in_if.valid = 1'b0;
    checks++;
    if (count !== 3'd3 || out_if.data !== 4'd3) begin
      errors++; $display("[TB] FAIL fullpop_cycle2: got count=%0d head=%0d expected 3/3", count, out_if.data);
    end
    for (int k = 3; k <= 5; k++) begin
      checks++;
      if (out_if.valid !== 1'b1 || out_if.data !== 4'(k)) begin
        errors++; $display("[TB] FAIL fullpop_drain_%0d: got valid=%b data=%0d expected 1/%0d", k, out_if.valid, out_if.data, k);
      end
      step();
    end
    checks++;
    if (out_if.valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("[TB] FAIL fullpop_empty: got valid=%b count=%0d expected 0/0", out_if.valid, count);
    end
  endtask

  task automatic test_reset_mid();
    out_if.ready = 1'b0;
    in_if.valid = 1'b1;
    for (int i = 6; i <= 8; i++) begin
      in_if.data = 4'(i);
      step();
    end
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("[TB] FAIL rstmid_pre: got count=%0d expected 3", count);
    end
    rst = 1'b0;
    in_if.data = 4'd9;
    out_if.ready = 1'b1;
    step();
    checks++;
    if (count !== 3'd0 || out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rstmid_after: got count=%0d valid=%b ready=%b expected 0/0/1", count, out_if.valid, in_if.ready);
    end
`ifdef ARB_OUT_FIFO_STATS_EN
    checks++;
    if (stall_cnt !== 16'd0 || full_seen !== 1'b0) begin
      errors++; $display("[TB] FAIL rstmid_stats: got stall=%0d full_seen=%b expected 0/0", stall_cnt, full_seen);
    end
`endif
    rst = 1'b1;
    in_if.data = 4'hA;
    out_if.ready = 1'b0;
    step();
    in_if.valid = 1'b0;
    checks++;
    if (count !== 3'd1 || out_if.valid !== 1'b1 || out_if.data !== 4'hA) begin
      errors++; $display("[TB] FAIL rstmid_first: got count=%0d valid=%b data=%0h expected 1/1/a", count, out_if.valid, out_if.data);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_full_pop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
